// File: rtl/mac_result_sink_if.sv
// Score-pair input stream and classified-result output stream of the MAC result sink.
// The producer/consumer side uses master and the sink uses slave.
interface mac_result_sink_if #(
  parameter int DATA_W    = 21,
  parameter int NUM_NODES = 16
);
  localparam int NODE_W = $clog2(NUM_NODES);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_score0;
  logic signed [DATA_W-1:0] in_score1;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_class;
  logic signed [DATA_W-1:0] out_score;
  logic [DATA_W:0]          out_margin;
  logic [NODE_W-1:0]        out_node;
  logic                     out_last;

  modport master (
    output in_valid, in_score0, in_score1, out_ready,
    input  out_valid, out_class, out_score, out_margin, out_node, out_last
  );

  modport slave (
    input  in_valid, in_score0, in_score1, out_ready,
    output out_valid, out_class, out_score, out_margin, out_node, out_last
  );
endinterface

// File: rtl/mac_result_sink.sv
// Classifies each MAC score pair (argmax, winning score, margin), tags it with a
// graph node index and buffers it in a first-word-fall-through FIFO.
module mac_result_sink #(
  parameter int DATA_W    = 21,
  parameter int DEPTH     = 8,
  parameter int NUM_NODES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mac_result_sink_if.slave       bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clr_overflow
);
  localparam int NODE_W = $clog2(NUM_NODES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Difference is formed one bit wider than the scores so it never wraps.
  function automatic logic [DATA_W:0] abs_diff(input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (d < 0) d = -d;
    return d;
  endfunction

  logic                     vld_p0;
  logic signed [DATA_W-1:0] s0_p0;
  logic signed [DATA_W-1:0] s1_p0;
  logic                     class_p0;
  logic signed [DATA_W-1:0] score_p0;
  logic [DATA_W:0]          margin_p0;

  // Stage p0: combinational classification of the incoming pair
  always_comb begin
    vld_p0    = bus.in_valid;
    s0_p0     = bus.in_score0;
    s1_p0     = bus.in_score1;
    class_p0  = (s1_p0 > s0_p0);
    score_p0  = class_p0 ? s1_p0 : s0_p0;
    margin_p0 = abs_diff(s0_p0, s1_p0);
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [NODE_W-1:0] node_cnt;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign full = (fifo_count == CNT_W'(DEPTH));
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = vld_p0 && (!full || pop);
  assign drop = vld_p0 && full && !pop;

  logic                     mem_class  [DEPTH];
  logic signed [DATA_W-1:0] mem_score  [DEPTH];
  logic [DATA_W:0]          mem_margin [DEPTH];
  logic [NODE_W-1:0]        mem_node   [DEPTH];

  // Storage stage: entry written at wr_ptr
  always_ff @(posedge clk) begin
    if (push) begin
      mem_class[wr_ptr]  <= class_p0;
      mem_score[wr_ptr]  <= score_p0;
      mem_margin[wr_ptr] <= margin_p0;
      mem_node[wr_ptr]   <= node_cnt;
    end
  end

  // Node tag counts every pair, dropped ones included, to stay frame-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      node_cnt   <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (vld_p0) begin
        if (node_cnt == NODE_W'(NUM_NODES - 1)) node_cnt <= '0;
        else                                     node_cnt <= node_cnt + NODE_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Head fields are gated so an empty FIFO presents zeros.
  always_comb begin
    bus.out_valid  = (fifo_count != '0);
    bus.out_class  = bus.out_valid && mem_class[rd_ptr];
    bus.out_score  = bus.out_valid ? mem_score[rd_ptr] : '0;
    bus.out_margin = bus.out_valid ? mem_margin[rd_ptr] : '0;
    bus.out_node   = bus.out_valid ? mem_node[rd_ptr] : '0;
    bus.out_last   = bus.out_valid && (mem_node[rd_ptr] == NODE_W'(NUM_NODES - 1));
  end
endmodule
